// File: rtl/vga_pkg.sv
// Shared types for the VGA colour-capture path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

  localparam int COLOR_W_DEF = 24;

  typedef logic [COLOR_W_DEF-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } dbnc_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser plus debounce FSM producing one strobe per accepted press.
// Latency: strobe appears 3+DEBOUNCE_CYC edges after the raw button goes and stays high.
// Backpressure: none; bounces shorter than DEBOUNCE_CYC and releases produce no strobe.
module btn_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic iclk,
  input  logic irst,
  input  logic ibtn,
  output logic opress
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             btn_m;
  logic             btn_s;
  dbnc_state_t      state;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; the only place the raw button is sampled.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= ibtn;
      btn_s <= btn_m;
    end
  end

  // Debounce FSM: a level must hold for DEBOUNCE_CYC cycles; strobe only on accepted press.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state  <= IDLE;
      cnt    <= '0;
      opress <= 1'b0;
    end else begin
      opress <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state  <= HELD;
            opress <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/color_palette_ctrl.sv
// Button-driven colour capture into an N-entry palette with registered read port.
// Latency: capture one edge after owr_pulse; read data one edge after irsel.
// Backpressure: none; when full and WRAP=0 further presses are dropped, clear beats capture.
module color_palette_ctrl
  import vga_pkg::*;
#(
  parameter int NUM_COLORS   = 4,
  parameter int COLOR_W      = COLOR_W_DEF,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int WRAP         = 1,
  localparam int IW          = (NUM_COLORS > 2) ? $clog2(NUM_COLORS) : 1,
  localparam int CW          = $clog2(NUM_COLORS + 1)
) (
  input  logic               iclk,
  input  logic               irst,
  input  logic               ibtn,
  input  logic [COLOR_W-1:0] icolor,
  input  logic               iclear,
  input  logic [IW-1:0]      irsel,
  output logic [COLOR_W-1:0] ordata,
  output logic [IW-1:0]      oidx,
  output logic [CW-1:0]      ocount,
  output logic               ofull,
  output logic               owr_pulse
);

  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_COLORS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_COLORS);

  logic [COLOR_W-1:0] palette [NUM_COLORS];
  logic               capture;
  logic [IW-1:0]      idx_nxt;
  logic [CW-1:0]      cnt_nxt;

  // The debouncer's registered strobe is the write pulse; capture happens on the following edge.
  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_debounce (
    .iclk  (iclk),
    .irst  (irst),
    .ibtn  (ibtn),
    .opress(owr_pulse)
  );

  // Next write index (wrapping) and saturating count for an accepted capture.
  always_comb begin
    capture = owr_pulse && (!ofull || (WRAP != 0)) && !iclear;
    idx_nxt = (oidx == IDX_LAST) ? '0 : oidx + IW'(1);
    cnt_nxt = (ocount == CNT_MAX) ? ocount : ocount + CW'(1);
  end

  // Write index, count and full flag; clear takes priority over a same-cycle capture.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      oidx   <= '0;
      ocount <= '0;
      ofull  <= 1'b0;
    end else if (iclear) begin
      oidx   <= '0;
      ocount <= '0;
      ofull  <= 1'b0;
    end else if (capture) begin
      oidx   <= idx_nxt;
      ocount <= cnt_nxt;
      ofull  <= (cnt_nxt == CNT_MAX);
    end
  end

  // Palette storage; contents survive a clear and are only zeroed by reset.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        palette[i] <= '0;
      end
    end else if (capture) begin
      palette[oidx] <= icolor;
    end
  end

  // Registered read port; same-cycle read of the slot being written returns the old value.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      ordata <= '0;
    end else if (int'(irsel) < NUM_COLORS) begin
      ordata <= palette[irsel];
    end else begin
      ordata <= '0;
    end
  end

endmodule

// File: tb/tb_color_palette_ctrl.sv
// Bench for color_palette_ctrl: two instances (WRAP=1 and WRAP=0) on shared stimulus.
// Latency: checks pulse timing at 3+D edges after press, capture at the following edge.
// Backpressure: n/a.
module tb_color_palette_ctrl;
  import vga_pkg::*;

  localparam int NC = 4;
  localparam int D  = 4;

  logic        iclk;
  logic        irst;
  logic        ibtn;
  logic [23:0] icolor;
  logic        iclear;
  logic [1:0]  irsel;

  logic [23:0] ordata_a, ordata_b;
  logic [1:0]  oidx_a, oidx_b;
  logic [2:0]  ocount_a, ocount_b;
  logic        ofull_a, ofull_b;
  logic        owr_a, owr_b;

  color_palette_ctrl #(
    .NUM_COLORS(NC), .COLOR_W(24), .DEBOUNCE_CYC(D), .WRAP(1)
  ) dut_a (
    .iclk(iclk), .irst(irst), .ibtn(ibtn), .icolor(icolor), .iclear(iclear),
    .irsel(irsel), .ordata(ordata_a), .oidx(oidx_a), .ocount(ocount_a),
    .ofull(ofull_a), .owr_pulse(owr_a)
  );

  color_palette_ctrl #(
    .NUM_COLORS(NC), .COLOR_W(24), .DEBOUNCE_CYC(D), .WRAP(0)
  ) dut_b (
    .iclk(iclk), .irst(irst), .ibtn(ibtn), .icolor(icolor), .iclear(iclear),
    .irsel(irsel), .ordata(ordata_b), .oidx(oidx_b), .ocount(ocount_b),
    .ofull(ofull_b), .owr_pulse(owr_b)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int cyc = 0;
  int npulse_a = 0;
  int npulse_b = 0;
  int last_pulse = -1;
  int checks = 0;
  int fails = 0;

  // Reference model: index 0 = WRAP=1 instance, index 1 = WRAP=0 instance.
  color_t m_pal [2][NC];
  int     m_idx [2];
  int     m_cnt [2];

  always @(posedge iclk) cyc <= cyc + 1;

  always @(negedge iclk) begin
    if (owr_a === 1'b1) begin
      npulse_a++;
      last_pulse = cyc;
    end
    if (owr_b === 1'b1) npulse_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < NC; s++) m_pal[w][s] = '0;
      m_idx[w] = 0;
      m_cnt[w] = 0;
    end
  endtask

  task automatic model_press(input color_t col, input bit clr);
    for (int w = 0; w < 2; w++) begin
      if (clr) begin
        m_idx[w] = 0;
        m_cnt[w] = 0;
      end else if (m_cnt[w] < NC || w == 0) begin
        m_pal[w][m_idx[w]] = col;
        m_idx[w] = (m_idx[w] + 1) % NC;
        m_cnt[w] = (m_cnt[w] + 1 > NC) ? NC : m_cnt[w] + 1;
      end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_oidx_a"},   32'(oidx_a),   32'(m_idx[0]));
    chk({tag, "_ocount_a"}, 32'(ocount_a), 32'(m_cnt[0]));
    chk({tag, "_ofull_a"},  32'(ofull_a),  32'(m_cnt[0] == NC));
    chk({tag, "_oidx_b"},   32'(oidx_b),   32'(m_idx[1]));
    chk({tag, "_ocount_b"}, 32'(ocount_b), 32'(m_cnt[1]));
    chk({tag, "_ofull_b"},  32'(ofull_b),  32'(m_cnt[1] == NC));
  endtask

  task automatic read_chk(input int s);
    @(posedge iclk); #1;
    irsel = 2'(s);
    @(posedge iclk); #1;
    chk($sformatf("rd_a_slot%0d", s), 32'(ordata_a), 32'(m_pal[0][s]));
    chk($sformatf("rd_b_slot%0d", s), 32'(ordata_b), 32'(m_pal[1][s]));
  endtask

  task automatic read_all();
    for (int s = 0; s < NC; s++) read_chk(s);
  endtask

  // Clean press; icolor carries a decoy except around the capture edge.
  task automatic do_press(input color_t col, input bit clr);
    int e, p0, pb0;
    @(posedge iclk); #1;
    e = cyc; p0 = npulse_a; pb0 = npulse_b;
    icolor = ~col;
    ibtn = 1'b1;
    repeat (D + 3) @(posedge iclk);
    #1;
    icolor = col;
    if (clr) iclear = 1'b1;
    @(posedge iclk); #1;
    iclear = 1'b0;
    icolor = 24'($urandom);
    repeat (2) @(posedge iclk);
    #1;
    ibtn = 1'b0;
    repeat (D + 5) @(posedge iclk);
    #1;
    chk("press_pulses_a", 32'(npulse_a - p0), 32'd1);
    chk("press_pulses_b", 32'(npulse_b - pb0), 32'd1);
    chk("press_pulse_cycle", 32'(last_pulse), 32'(e + 3 + D));
    model_press(col, clr);
    check_state(clr ? "press_clr" : "press");
  endtask

  int     e, r, p0;
  color_t col;

  initial begin
    irst = 1'b0; ibtn = 1'b0; icolor = '0; iclear = 1'b0; irsel = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_ordata_a", 32'(ordata_a), 32'd0);
    chk("rst_owr_a", 32'(owr_a), 32'd0);
    chk("rst_owr_b", 32'(owr_b), 32'd0);
    check_state("rst");
    irst = 1'b1;
    read_all();

    // Clean press with red, then confirm slot 0 holds it
    do_press(24'hFF0000, 1'b0);
    chk("clean_slot0_const", 32'(m_pal[0][0]), 32'h00FF0000);
    read_chk(0);

    // Bounce rejection: two short highs, then a real hold
    @(posedge iclk); #1;
    p0 = npulse_a;
    col = 24'($urandom);
    icolor = col;
    for (int k = 0; k < 2; k++) begin
      ibtn = 1'b1;
      repeat (2) @(posedge iclk);
      #1;
      ibtn = 1'b0;
      repeat (2) @(posedge iclk);
      #1;
    end
    chk("bounce_no_early_pulse", 32'(npulse_a - p0), 32'd0);
    e = cyc;
    ibtn = 1'b1;
    repeat (10) @(posedge iclk);
    #1;
    ibtn = 1'b0;
    repeat (D + 5) @(posedge iclk);
    #1;
    chk("bounce_pulses", 32'(npulse_a - p0), 32'd1);
    chk("bounce_pulse_cycle", 32'(last_pulse), 32'(e + 3 + D));
    model_press(col, 1'b0);
    check_state("bounce");
    read_chk(1);

    // Standalone clear: index and count drop, contents kept
    @(posedge iclk); #1;
    iclear = 1'b1;
    @(posedge iclk); #1;
    iclear = 1'b0;
    model_press('0, 1'b1);
    check_state("clear");
    read_all();

    // Wrap versus no-wrap: five presses 1..5
    for (int k = 1; k <= 5; k++) begin
      do_press(24'(k), 1'b0);
      if (k == 4) begin
        chk("full_after4_a", 32'(ofull_a), 32'd1);
        chk("full_after4_b", 32'(ofull_b), 32'd1);
      end
    end
    chk("wrap_oidx_a", 32'(oidx_a), 32'd1);
    chk("wrap_ocount_a", 32'(ocount_a), 32'd4);
    chk("nowrap_oidx_b", 32'(oidx_b), 32'd0);
    read_all();

    // Clear colliding with the write pulse: no write, index/count cleared
    do_press(24'($urandom), 1'b1);
    read_all();
    do_press(24'($urandom), 1'b0);
    read_chk(0);

    // Randomised presses with occasional clear collisions and reads
    for (int k = 0; k < 6; k++) begin
      do_press(24'($urandom), ($urandom_range(0, 3) == 0));
      read_chk(int'($urandom_range(0, NC - 1)));
    end

    // Reset two cycles into the press debounce, button still held
    @(posedge iclk); #1;
    e = cyc; p0 = npulse_a;
    col = 24'($urandom);
    icolor = col;
    ibtn = 1'b1;
    repeat (5) @(posedge iclk);
    #1;
    irst = 1'b0;
    chk("midrst_no_pulse", 32'(npulse_a - p0), 32'd0);
    @(posedge iclk); #1;
    irst = 1'b1;
    r = cyc;
    model_reset();
    repeat (D + 5) @(posedge iclk);
    #1;
    ibtn = 1'b0;
    repeat (D + 5) @(posedge iclk);
    #1;
    chk("midrst_pulses", 32'(npulse_a - p0), 32'd1);
    chk("midrst_pulse_cycle", 32'(last_pulse), 32'(r + 3 + D));
    model_press(col, 1'b0);
    check_state("midrst");
    read_all();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/color_palette_ctrl.md
# color_palette_ctrl

Parametrised colour-capture controller for the VGA path. A raw push-button is synchronised and debounced. Each clean press latches the colour on `icolor` into the next slot of an N-entry palette register bank. The VGA pixel logic reads any slot through a registered read port. This block supersedes the fixed 4×24-bit button-driven colour store and adds configurable depth and width, debouncing, full/wrap policy, clear, and status outputs.

## Interface
- `NUM_COLORS`, 4: palette depth; must be ≥ 2.
- `COLOR_W`, 24: bits per colour (8:8:8 RGB at default).
- `DEBOUNCE_CYC`, 1_000_000: consecutive stable cycles required to accept a level change; ≥ 1; benches use 4.
- `WRAP`, 1: when 1, overwrite from slot 0 once full; when 0, ignore presses once full.
- `iclk` in 1: the single clock domain.
- `irst` in 1: reset, asynchronous assert, active-low; release is synchronous to `iclk` upstream.
- `ibtn` in 1: raw, asynchronous, bouncing button; active-high.
- `icolor` in COLOR_W: colour sampled on the capture edge.
- `iclear` in 1: synchronous clear of write index and count; palette contents are kept.
- `irsel` in IW: read slot select, where IW = max(1, $clog2(NUM_COLORS)).
- `ordata` out COLOR_W: registered palette[`irsel`].
- `oidx` out IW: next slot to be written.
- `ocount` out $clog2(NUM_COLORS+1): number of valid slots, saturating at NUM_COLORS.
- `ofull` out 1: high when `ocount` == NUM_COLORS.
- `owr_pulse` out 1: one-cycle strobe the cycle before a palette write.

## Operation
- **Reset (`irst`=0).** All palette slots = 0; `ordata`, `oidx`, `ocount`, `ofull`, `owr_pulse` = 0; debounce FSM = IDLE, counter = 0; synchroniser flops = 0.
- **Synchroniser.** `ibtn` passes through 2 flops to give `btn_s`. Nothing else samples `ibtn`.
- **Debounce FSM**, one counter `cnt` with width $clog2(DEBOUNCE_CYC)+1:
  - IDLE: `btn_s`=1 → PRESS_WAIT, cnt=0.
  - PRESS_WAIT: `btn_s`=0 → IDLE. Otherwise, if cnt==DEBOUNCE_CYC-1 → HELD and assert press strobe; else cnt+1.
  - HELD: `btn_s`=0 → RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: `btn_s`=1 → HELD. Otherwise, if cnt==DEBOUNCE_CYC-1 → IDLE; else cnt+1.
  - Exactly one strobe per accepted press. Release generates no strobe. A bounce shorter than DEBOUNCE_CYC generates nothing.
- **Capture**, on `owr_pulse`=1:
  - If not full, or `WRAP`=1: palette[`oidx`] ← `icolor`; `oidx` ← (`oidx`==NUM_COLORS-1) ? 0 : `oidx`+1; `ocount` ← min(`ocount`+1, NUM_COLORS).
  - If full and `WRAP`=0: no write, no state change.
- **Clear.** `iclear`=1 → `oidx`=0 and `ocount`=0 next edge.
  - `iclear` together with `owr_pulse` in the same cycle: clear wins, the capture is dropped, and the palette is unchanged.
- **Read.** `ordata` ← palette[`irsel`] every cycle.
  - If `irsel` ≥ NUM_COLORS (non-power-of-2 depth), `ordata` ← 0.
  - A read of the slot being written in the same cycle returns the old value.
- **`ofull`** is registered and consistent with `ocount` in the same cycle.

## Timing
- D = DEBOUNCE_CYC.
- `ibtn` rises before edge k and stays high: `btn_s` is high after edge k+2, FSM enters PRESS_WAIT at k+3, and `owr_pulse` is high from edge k+3+D for exactly 1 cycle.
- `icolor` is sampled at edge k+4+D; palette, `oidx`, `ocount` and `ofull` update at that same edge.
- Read latency is 1 cycle from `irsel` to `ordata`.
- Minimum press-to-press spacing: D cycles high, then D cycles low.
- `irst` asserted mid-debounce or mid-press: the pending strobe is lost. After release the FSM starts in IDLE; a button still held produces a fresh press after D+3 cycles.

## Structure
- Package `vga_pkg` holds:
  - `COLOR_W_DEF` = 24 and `typedef logic [COLOR_W_DEF-1:0] color_t`;
  - `typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} dbnc_state_t`.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYC`; ports `iclk`, `irst`, `ibtn`, `opress`) contains the synchroniser and FSM.
- Palette storage, index/count logic and read mux live in `color_palette_ctrl`.

## Test plan
All scenarios use NUM_COLORS=4, COLOR_W=24, D=4.
- **Reset state.** Assert `irst` low for 3 cycles → all outputs 0; `irsel`=0..3 read 0x000000.
- **Clean press.** `ibtn` high from edge 10 with `icolor`=0xFF0000 → `owr_pulse` high in cycle 17 only; palette[0]=0xFF0000 at edge 18; `oidx`=1, `ocount`=1.
- **Bounce rejection.** `ibtn` toggles 1,0,1,0 every 2 cycles, then high for 10 cycles → exactly one `owr_pulse`.
- **Wrap.** `WRAP`=1; 5 presses with 0x000001..0x000005 → `ofull`=1 after the 4th press; palette[0]=0x000005; `oidx`=1; `ocount`=4.
  - Repeat with `WRAP`=0 → palette[0]=0x000001; `oidx`=0; 5th press ignored.
- **Clear collision.** `iclear`=1 in the `owr_pulse` cycle → `oidx`=0, `ocount`=0, target slot unchanged.
  - Next press writes slot 0.
- **Reset mid-press.** `irst` low for 1 cycle 2 cycles into PRESS_WAIT, button still held → no pulse before reset.
  - After release, one pulse D+3 cycles later; palette otherwise 0.
